// File: rtl/collision_pkg.sv
// Shared types and constants for the collision detector back end.
package collision_pkg;

  localparam int LINE_ID_W     = 8;
  localparam int MAX_LINES_DEF = 64;
  localparam logic [LINE_ID_W-1:0] LINE_ID_NONE = 8'hFF;

  typedef logic [LINE_ID_W-1:0] line_id_t;

  // IDs are 1-based; 0 and anything above the tracked range are not lines.
  function automatic logic is_legal_id(input line_id_t id, input int max_lines);
    return (id != '0) && (int'(id) <= max_lines);
  endfunction

endpackage

// File: rtl/collision_fifo.sv
// First-word-fall-through circular queue; pushes beyond capacity are refused internally.
module collision_fifo
  import collision_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  line_id_t push_data,
  input  logic     pop,
  output line_id_t rd_data,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  line_id_t        mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full queue is only taken when the same cycle frees a slot.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/collision_log.sv
// Logs each unique colliding line ID once into a FIFO, with a saturating count and sticky overflow.
module collision_log
  import collision_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int MAX_LINES = MAX_LINES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       det_val,
  input  line_id_t   det_line_id,
  input  logic       clear,
  output logic       rd_val,
  output line_id_t   rd_id,
  input  logic       rd_rdy,
  output logic [6:0] uniq_count,
  output logic       any_hit,
  output logic       overflow
);

  localparam int IDX_W = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

  logic                 flush;
  logic                 det_val_p0;
  line_id_t             det_id_p0;
  logic [MAX_LINES-1:0] seen;
  logic [IDX_W-1:0]     idx;
  logic                 new_unique;
  logic                 full;
  logic                 empty;
  logic                 pop;

  assign flush = reset || clear;

  // Stage p0: register the detector report; only the valid is flushed.
  always_ff @(posedge clk) begin
    if (flush) det_val_p0 <= 1'b0;
    else       det_val_p0 <= det_val;
  end

  always_ff @(posedge clk) begin
    det_id_p0 <= det_line_id;
  end

  assign idx        = IDX_W'(det_id_p0 - 8'd1);
  assign new_unique = det_val_p0 && is_legal_id(det_id_p0, MAX_LINES) && !seen[idx];
  assign pop        = rd_val && rd_rdy;
  assign rd_val     = !empty;
  assign any_hit    = (uniq_count != 7'd0);

  // Stage p1: bitmap, count and overflow commit; the queue push lands here too.
  always_ff @(posedge clk) begin
    if (flush) begin
      seen       <= '0;
      uniq_count <= '0;
      overflow   <= 1'b0;
    end else if (new_unique) begin
      seen[idx] <= 1'b1;
      if (uniq_count != 7'd127) uniq_count <= uniq_count + 7'd1;
      if (full && !pop) overflow <= 1'b1;
    end
  end

  collision_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (flush),
    .push      (new_unique),
    .push_data (det_id_p0),
    .pop       (pop),
    .rd_data   (rd_id),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_collision_log.sv
// Directed bench for collision_log with a 4-entry queue.
module tb_collision_log;

  logic       clk = 1'b0;
  logic       reset;
  logic       det_val;
  logic [7:0] det_line_id;
  logic       clear;
  logic       rd_val;
  logic [7:0] rd_id;
  logic       rd_rdy;
  logic [6:0] uniq_count;
  logic       any_hit;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  collision_log #(
    .DEPTH     (4),
    .MAX_LINES (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .det_val     (det_val),
    .det_line_id (det_line_id),
    .clear       (clear),
    .rd_val      (rd_val),
    .rd_id       (rd_id),
    .rd_rdy      (rd_rdy),
    .uniq_count  (uniq_count),
    .any_hit     (any_hit),
    .overflow    (overflow)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] id);
    det_val     = 1'b1;
    det_line_id = id;
    tick();
  endtask

  task automatic idle(input int n);
    det_val     = 1'b0;
    det_line_id = 8'hFF;
    tick(n);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] id);
    chk({tag, "_val"}, 32'(rd_val), 32'd1);
    chk({tag, "_id"}, 32'(rd_id), 32'(id));
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    clear       = 1'b0;
    det_val     = 1'b0;
    det_line_id = 8'hFF;
    rd_rdy      = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(20);
    chk("rst_rd_val", 32'(rd_val), 32'd0);
    chk("rst_count", 32'(uniq_count), 32'd0);
    chk("rst_any_hit", 32'(any_hit), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // ID 5 held four cycles, then ID 9 once.
    send(8'd5);
    chk("lat1_rd_val", 32'(rd_val), 32'd0);
    send(8'd5);
    chk("lat2_rd_val", 32'(rd_val), 32'd1);
    chk("lat2_rd_id", 32'(rd_id), 32'd5);
    chk("lat2_count", 32'(uniq_count), 32'd1);
    chk("lat2_any_hit", 32'(any_hit), 32'd1);
    send(8'd5);
    send(8'd5);
    send(8'd9);
    idle(3);
    chk("rep_count", 32'(uniq_count), 32'd2);
    pop_expect("rep_pop5", 8'd5);
    pop_expect("rep_pop9", 8'd9);
    chk("rep_empty", 32'(rd_val), 32'd0);

    // Illegal IDs after a clear.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr1_count", 32'(uniq_count), 32'd0);
    send(8'd0);
    send(8'hFF);
    send(8'd65);
    idle(3);
    chk("ill_count", 32'(uniq_count), 32'd0);
    chk("ill_rd_val", 32'(rd_val), 32'd0);
    chk("ill_any_hit", 32'(any_hit), 32'd0);

    // Fill past capacity with no reader.
    for (int i = 1; i <= 6; i++) send(8'(i));
    idle(3);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(uniq_count), 32'd6);
    chk("ovf_rd_val", 32'(rd_val), 32'd1);
    send(8'd6);
    idle(3);
    chk("ovf_resend_count", 32'(uniq_count), 32'd6);

    // Full queue: pop and push of ID 7 coincide.
    send(8'd7);
    det_val = 1'b0;
    chk("fp_head", 32'(rd_id), 32'd1);
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
    idle(2);
    chk("fp_overflow", 32'(overflow), 32'd1);
    chk("fp_count", 32'(uniq_count), 32'd7);
    pop_expect("fp_pop2", 8'd2);
    pop_expect("fp_pop3", 8'd3);
    pop_expect("fp_pop4", 8'd4);
    pop_expect("fp_pop7", 8'd7);
    chk("fp_empty", 32'(rd_val), 32'd0);

    // Clear with three entries queued and ID 12 arriving in the clear cycle.
    send(8'd20);
    send(8'd21);
    send(8'd22);
    idle(3);
    chk("cq_rd_val", 32'(rd_val), 32'd1);
    chk("cq_count", 32'(uniq_count), 32'd10);
    clear       = 1'b1;
    det_val     = 1'b1;
    det_line_id = 8'd12;
    tick();
    clear = 1'b0;
    idle(0);
    chk("cq_clr_rd_val", 32'(rd_val), 32'd0);
    chk("cq_clr_count", 32'(uniq_count), 32'd0);
    chk("cq_clr_overflow", 32'(overflow), 32'd0);
    idle(3);
    chk("cq_lost_count", 32'(uniq_count), 32'd0);
    chk("cq_lost_rd_val", 32'(rd_val), 32'd0);
    send(8'd12);
    idle(2);
    chk("cq_new_count", 32'(uniq_count), 32'd1);
    pop_expect("cq_pop12", 8'd12);
    chk("cq_final_empty", 32'(rd_val), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
